// File: rtl/mini_alu_seq_mul_pkg.sv
// Shared MiniAlu definitions: ALU opcodes and the sequential multiplier state encoding.
package mini_alu_seq_mul_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpMul  = 4'd5,  // unsigned multiply
    OpSmul = 4'd6   // two's-complement multiply
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(alu_op_e op);
    return (op == OpMul) || (op == OpSmul);
  endfunction

  function automatic logic is_signed_mul_op(alu_op_e op);
    return op == OpSmul;
  endfunction

endpackage

// File: rtl/mini_alu_digit_mux.sv
// Radix-4 partial-product selector: picks 0, M, 2M or 3M for one multiplier digit.
module mini_alu_digit_mux #(
  parameter int unsigned Width = 8
) (
  input  logic [1:0]       digit_i,
  input  logic [Width-1:0] m_i,
  output logic [Width+1:0] pp_o
);

  logic [Width+1:0] m_x1;
  logic [Width+1:0] m_x2;

  assign m_x1 = {2'b00, m_i};
  assign m_x2 = {1'b0, m_i, 1'b0};

  always_comb begin
    pp_o = '0;
    unique case (digit_i)
      2'd0: pp_o = '0;
      2'd1: pp_o = m_x1;
      2'd2: pp_o = m_x2;
      2'd3: pp_o = m_x1 + m_x2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mini_alu_seq_mul.sv
// Iterative radix-4 multiplier: magnitude multiply over Width/2 steps, then sign fix-up.
module mini_alu_seq_mul
  import mini_alu_seq_mul_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [Width-1:0]     a_i,
  input  logic [Width-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*Width-1:0]   product_o
);

  localparam int unsigned HalfW = Width / 2;
  localparam int unsigned CntW  = $clog2(HalfW + 1);
  localparam int unsigned ProdW = 2 * Width;

  mul_state_e        state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [Width-1:0]  mcand_q, mcand_d;
  logic [Width-1:0]  mplier_q, mplier_d;
  logic [ProdW-1:0]  acc_q, acc_d;
  logic [ProdW-1:0]  product_q, product_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg;
  logic [Width-1:0]  a_mag, b_mag;
  logic              accept;
  logic [Width+1:0]  pp;
  logic [ProdW-1:0]  pp_ext;
  logic [CntW-1:0]   step_idx;
  logic [ProdW-1:0]  pp_shift;

  // Magnitude of -2^(Width-1) wraps to 2^(Width-1), which still fits unsigned.
  assign a_neg = signed_i & a_i[Width-1];
  assign b_neg = signed_i & b_i[Width-1];
  assign a_mag = a_neg ? (~a_i + Width'(1)) : a_i;
  assign b_mag = b_neg ? (~b_i + Width'(1)) : b_i;

  mini_alu_digit_mux #(
    .Width (Width)
  ) u_digit_mux (
    .digit_i (mplier_q[1:0]),
    .m_i     (mcand_q),
    .pp_o    (pp)
  );

  assign pp_ext   = {{(ProdW - Width - 2){1'b0}}, pp};
  assign step_idx = CntW'(HalfW) - count_q;
  assign pp_shift = pp_ext << {step_idx, 1'b0};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = start_i;
      end
      StRun: begin
        acc_d    = acc_q + pp_shift;
        mplier_d = mplier_q >> 2;
        count_d  = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        product_d = neg_q ? (~acc_q + ProdW'(1)) : acc_q;
        done_d    = 1'b1;
        state_d   = StIdle;
        accept    = start_i;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Acceptance from FIX allows back-to-back operations with no idle gap.
    if (accept) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = a_neg ^ b_neg;
      acc_d    = '0;
      count_d  = CntW'(HalfW);
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_mini_alu_seq_mul.sv
// Directed bench for mini_alu_seq_mul at Width=8 plus a randomised Width=16 instance.
module tb_mini_alu_seq_mul;

  logic        clk;
  logic        rst_n;
  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_fail   = 0;

  mini_alu_seq_mul #(
    .Width (8)
  ) u_dut8 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start8),
    .signed_i  (sgn8),
    .a_i       (a8),
    .b_i       (b8),
    .busy_o    (busy8),
    .done_o    (done8),
    .product_o (prod8)
  );

  mini_alu_seq_mul #(
    .Width (16)
  ) u_dut16 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start16),
    .signed_i  (sgn16),
    .a_i       (a16),
    .b_i       (b16),
    .busy_o    (busy16),
    .done_o    (done16),
    .product_o (prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps one edge at a time until done8, counting edges and busy samples.
  task automatic wait_done8(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    do begin
      if (busy8) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end while (!done8 && lat < 20);
  endtask

  // One accepted op; operands are scrambled right after acceptance.
  task automatic mul8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int lat, nb;
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    @(posedge clk);
    #1;
    start8 = 1'b0; sgn8 = ~s; a8 = ~a; b8 = b ^ 8'h5A;
    wait_done8(lat, nb);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check(tag, {16'h0, prod8}, {16'h0, exp});
  endtask

  initial begin
    int lat, nb;
    logic [7:0]  ops_a [3];
    logic [7:0]  ops_b [3];
    logic [15:0] ops_p [3];
    logic        any_done;

    rst_n = 1'b0; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy8}, 32'h0);
    check("rst_done", {31'h0, done8}, 32'h0);
    check("rst_prod", {16'h0, prod8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 13*11 with busy window and single-cycle done
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd13; b8 = 8'd11;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done8(lat, nb);
    check("t1_lat", 32'(lat), 32'd5);
    check("t1_busy_cycles", 32'(nb), 32'd5);
    check("t1_prod", {16'h0, prod8}, 32'h008F);
    check("t1_busy_at_done", {31'h0, busy8}, 32'h0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", {31'h0, done8}, 32'h0);
    check("t1_prod_hold", {16'h0, prod8}, 32'h008F);

    mul8("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01);
    mul8("s_m3x5", 1'b1, 8'hFD, 8'd5, 16'hFFF1);
    mul8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
    mul8("s_m128x127", 1'b1, 8'h80, 8'h7F, 16'hC080);
    mul8("u_128x255", 1'b0, 8'h80, 8'hFF, 16'h7F80);
    mul8("zero_a", 1'b0, 8'd0, 8'd77, 16'h0000);
    mul8("zero_b", 1'b1, 8'hC5, 8'd0, 16'h0000);

    // Back-to-back with iStart held high: accepted in FIX, done every 5 clocks
    ops_a[0] = 8'd3;  ops_b[0] = 8'd4;  ops_p[0] = 16'd12;
    ops_a[1] = 8'd5;  ops_b[1] = 8'd6;  ops_p[1] = 16'd30;
    ops_a[2] = 8'd7;  ops_b[2] = 8'd8;  ops_p[2] = 16'd56;
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = ops_a[0]; b8 = ops_b[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a8 = ops_a[i+1]; b8 = ops_b[i+1];
      end else begin
        start8 = 1'b0;
      end
      wait_done8(lat, nb);
      check($sformatf("b2b%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("b2b%0d_prod", i), {16'h0, prod8}, {16'h0, ops_p[i]});
    end

    // iStart pulsed during RUN is ignored
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("run_ign_lat", 32'(lat), 32'd3);
    check("run_ign_prod", {16'h0, prod8}, 32'd81);
    any_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      any_done = any_done | done8 | busy8;
    end
    check("run_ign_no_second_op", {31'h0, any_done}, 32'h0);

    // Reset in the 3rd RUN cycle of 200*200
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd200;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy8}, 32'h0);
    check("abort_done", {31'h0, done8}, 32'h0);
    check("abort_prod", {16'h0, prod8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      any_done = any_done | done8 | busy8;
    end
    check("abort_no_stale_done", {31'h0, any_done}, 32'h0);
    mul8("after_abort_7x6", 1'b0, 8'd7, 8'd6, 16'd42);

    // Width=16 random signed/unsigned against a behavioural product
    for (int i = 0; i < 300; i++) begin
      logic        s;
      logic [15:0] ra, rb;
      logic [31:0] exp;
      s  = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; s = 1'b1; end
      if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; s = 1'b0; end
      if (s) exp = 32'($signed(ra) * $signed(rb));
      else   exp = {16'h0, ra} * {16'h0, rb};
      @(negedge clk);
      start16 = 1'b1; sgn16 = s; a16 = ra; b16 = rb;
      @(posedge clk);
      #1;
      start16 = 1'b0; a16 = ~ra; b16 = ~rb;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!done16 && lat < 30);
      check($sformatf("w16_%0d_lat", i), 32'(lat), 32'd9);
      check($sformatf("w16_%0d_prod s=%0d a=%h b=%h", i, s, ra, rb), prod16, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
